mdu_sequencer: RTL

//  Sequencer for the EX-stage multiply/divide unit: accepts MIPS HI/LO ops, runs a multi-cycle multiply
//  and a radix-2 restoring divide, and owns the HI/LO registers. Raises a pipeline stall while a new
//  HI/LO op (incl. MFHI/MFLO) hits an in-flight op. Sits beside the ALU in EX; read_data feeds EX writeback mux.

---
 rtl/mdu_sequencer_if.sv | 28 ++
 rtl/mdu_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: EX-stage HI/LO op request and result bundle.
// master = EX pipeline side, slave = multiply/divide sequencer.
interface mdu_sequencer_if;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        stall_in;
  logic        flush;
  logic        busy;
  logic        mdu_stall;
  logic        done;
  logic [31:0] read_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, operand_a, operand_b,
    output stall_in, flush,
    input  busy, mdu_stall, done, read_data, hi, lo
  );

  modport slave (
    input  op_valid, op, operand_a, operand_b,
    input  stall_in, flush,
    output busy, mdu_stall, done, read_data, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/DIV sequencer owning HI/LO.
// Define MDU_DIV_EARLY_OUT_EN for one-cycle trivial divides.
module mdu_sequencer #(
  parameter int MUL_CYCLES = 5
) (
  input logic            clk,
  input logic            rst,
  mdu_sequencer_if.slave mdu
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic        r_qneg, r_rneg, r_dz, r_done;

  logic        w_vld, w_busy, w_acc, w_last;
  logic        w_mul, w_div, w_sgn;
  logic [63:0] w_ax, w_bx;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_sh, w_diff;
  logic [31:0] w_nrem, w_nquo;
  logic [31:0] w_quo_f, w_rem_f;
  logic [31:0] w_res_lo, w_res_hi;
  logic [5:0]  w_div_cnt;

  assign w_vld  = (mdu.op != 4'd0) && (mdu.op <= OP_MFLO);
  assign w_busy = (r_state != S_IDLE);
  assign w_acc  = mdu.op_valid & w_vld & ~w_busy
                & ~mdu.stall_in & ~mdu.flush & ~rst;
  assign w_mul  = (mdu.op == OP_MULT) | (mdu.op == OP_MULTU);
  assign w_div  = (mdu.op == OP_DIV) | (mdu.op == OP_DIVU);
  assign w_sgn  = (mdu.op == OP_MULT) | (mdu.op == OP_DIV);
  assign w_last = w_busy & (r_cnt == 6'd1) & ~mdu.flush;

  assign w_ax = {{32{w_sgn & mdu.operand_a[31]}}, mdu.operand_a};
  assign w_bx = {{32{w_sgn & mdu.operand_b[31]}}, mdu.operand_b};
  assign w_abs_a = (w_sgn & mdu.operand_a[31]) ? -mdu.operand_a
                                               : mdu.operand_a;
  assign w_abs_b = (w_sgn & mdu.operand_b[31]) ? -mdu.operand_b
                                               : mdu.operand_b;

  // one restoring step: dividend bits shift out of r_quo into r_rem
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_diff = w_sh - {1'b0, r_dvs};
  assign w_nrem = w_diff[32] ? w_sh[31:0] : w_diff[31:0];
  assign w_nquo = {r_quo[30:0], ~w_diff[32]};

`ifdef MDU_DIV_EARLY_OUT_EN
  logic r_early;
  logic w_early;

  assign w_early   = (w_abs_b == 32'd0) | (w_abs_a < w_abs_b);
  assign w_div_cnt = w_early ? 6'd1 : 6'd32;
  assign w_quo_f   = r_early ? 32'd0 : w_nquo;
  assign w_rem_f   = r_early ? r_quo : w_nrem;

  always_ff @(posedge clk) begin
    if (rst)
      r_early <= 1'b0;
    else if (w_acc & w_div)
      r_early <= w_early;
  end
`else
  assign w_div_cnt = 6'd32;
  assign w_quo_f   = w_nquo;
  assign w_rem_f   = w_nrem;
`endif

  // remainder sign fix also restores operand_a on divide by zero
  assign w_res_lo = r_dz ? 32'hFFFF_FFFF
                         : (r_qneg ? -w_quo_f : w_quo_f);
  assign w_res_hi = r_rneg ? -w_rem_f : w_rem_f;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      mdu.flush:      w_next = S_IDLE;
      w_acc && w_mul: w_next = S_MUL;
      w_acc && w_div: w_next = S_DIV;
      w_last:         w_next = S_IDLE;
      default:        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 6'd0;
      r_prod <= 64'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_quo  <= 32'd0;
      r_rem  <= 32'd0;
      r_dvs  <= 32'd0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (mdu.flush)
        r_cnt <= 6'd0;
      else if (w_busy)
        r_cnt <= r_cnt - 6'd1;
      if (r_state == S_DIV) begin
        r_rem <= w_nrem;
        r_quo <= w_nquo;
      end
      if (w_acc) begin
        unique case (1'b1)
          w_mul: begin
            r_prod <= w_ax * w_bx;
            r_cnt  <= 6'(MUL_CYCLES);
          end
          w_div: begin
            r_quo  <= w_abs_a;
            r_rem  <= 32'd0;
            r_dvs  <= w_abs_b;
            r_qneg <= w_sgn & (mdu.operand_a[31] ^ mdu.operand_b[31]);
            r_rneg <= w_sgn & mdu.operand_a[31];
            r_dz   <= (mdu.operand_b == 32'd0);
            r_cnt  <= w_div_cnt;
          end
          (mdu.op == OP_MTHI): r_hi <= mdu.operand_a;
          (mdu.op == OP_MTLO): r_lo <= mdu.operand_a;
          default: ;
        endcase
      end
      if (w_last) begin
        if (r_state == S_MUL) begin
          r_hi <= r_prod[63:32];
          r_lo <= r_prod[31:0];
        end else begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end
  end

  assign mdu.busy      = w_busy;
  assign mdu.done      = r_done;
  assign mdu.mdu_stall = mdu.op_valid & w_vld & w_busy & ~mdu.flush;
  assign mdu.hi        = r_hi;
  assign mdu.lo        = r_lo;
  assign mdu.read_data = (mdu.op == OP_MFHI) ? r_hi :
                         (mdu.op == OP_MFLO) ? r_lo : 32'd0;
endmodule
